// File: rtl/fetch_issue.sv
// fetch_issue: bundle fetch engine with a registered issue queue, redirect flush and fetch gating.
// Define FETCH_HAZARD_SPLIT_EN to split bundles at intra-bundle RAW hazards.
module fetch_issue #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned PC_W   = 12,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [LANES*32-1:0]   imem_rdata,
    input  logic                  redirect_valid,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [LANES*32-1:0]   issue_bundle,
    output logic [LANES-1:0]      issue_lane_valid,
    output logic [PC_W-1:0]       issue_pc
);
    localparam int unsigned BW    = LANES * 32;
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BW-1:0]    data_q [QDEPTH];
    logic [PC_W-1:0]  qpc_q  [QDEPTH];

    logic             fetch_ok;
    logic             hs;
    logic             pop;
    logic             push;
    logic             all_issued;
    logic [LANES-1:0] lane_mask;

    // In-flight responses count against capacity so the queue can never overflow.
    assign fetch_ok  = (32'(count_q) + 32'(pend_q)) < QDEPTH;
    assign imem_req  = !rst && !redirect_valid && fetch_ok;
    assign imem_addr = pc_q;

    assign issue_valid      = (count_q != '0);
    assign issue_bundle     = data_q[rd_ptr_q];
    assign issue_pc         = qpc_q[rd_ptr_q];
    assign issue_lane_valid = issue_valid ? lane_mask : '0;

    assign hs   = issue_valid && issue_ready && !redirect_valid;
    assign pop  = hs && all_issued;
    assign push = pend_q && !redirect_valid;

`ifdef FETCH_HAZARD_SPLIT_EN
    logic [LANES-1:0] issued_q, issued_d;
    logic [6:0]       lane_op  [LANES];
    logic [4:0]       lane_rd  [LANES];
    logic [4:0]       lane_rs1 [LANES];
    logic [4:0]       lane_rs2 [LANES];
    logic [LANES-1:0] lane_wr, lane_r1, lane_r2, lane_haz;

    // Decode register usage of each lane of the head bundle; lane 0 sits in the MSBs.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_op[k]  = issue_bundle[(LANES-1-k)*32 +: 7];
            lane_rd[k]  = issue_bundle[(LANES-1-k)*32 + 7 +: 5];
            lane_rs1[k] = issue_bundle[(LANES-1-k)*32 + 15 +: 5];
            lane_rs2[k] = issue_bundle[(LANES-1-k)*32 + 20 +: 5];
            lane_wr[k]  = (lane_rd[k] != 5'd0) &&
                          (lane_op[k] == 7'b0110011 || lane_op[k] == 7'b0010011 ||
                           lane_op[k] == 7'b0000011 || lane_op[k] == 7'b0110111 ||
                           lane_op[k] == 7'b0010111 || lane_op[k] == 7'b1101111 ||
                           lane_op[k] == 7'b1100111);
            lane_r1[k]  = !(lane_op[k] == 7'b0110111 || lane_op[k] == 7'b0010111 ||
                            lane_op[k] == 7'b1101111);
            lane_r2[k]  = (lane_op[k] == 7'b0110011 || lane_op[k] == 7'b0100011 ||
                           lane_op[k] == 7'b1100011);
        end
    end

    // A lane is hazarded when it reads a register written by an earlier unissued lane.
    always_comb begin
        lane_haz = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < LANES; j++) begin
                if (j < k && !issued_q[j] && lane_wr[j] &&
                    ((lane_r1[k] && lane_rs1[k] == lane_rd[j]) ||
                     (lane_r2[k] && lane_rs2[k] == lane_rd[j]))) begin
                    lane_haz[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin : split_mask
        logic started;
        logic stop;
        lane_mask = '0;
        started   = 1'b0;
        stop      = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (!issued_q[k] && !stop) begin
                if (started && lane_haz[k]) begin
                    stop = 1'b1;
                end else begin
                    lane_mask[k] = 1'b1;
                    started      = 1'b1;
                end
            end
        end
    end

    assign all_issued = ((issued_q | lane_mask) == '1);

    always_comb begin
        issued_d = issued_q;
        if (redirect_valid || pop) begin
            issued_d = '0;
        end else if (hs) begin
            issued_d = issued_q | lane_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
        end else begin
            issued_q <= issued_d;
        end
    end
`else
    assign lane_mask  = '1;
    assign all_issued = 1'b1;
`endif

    // Fetch PC, in-flight tracking and queue pointers.
    always_comb begin
        pc_d      = pc_q;
        pend_d    = imem_req;
        pend_pc_d = imem_req ? pc_q : pend_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        if (imem_req) begin
            pc_d = pc_q + PC_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            qpc_q[wr_ptr_q]  <= pend_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: reset, streaming, stall, redirect, PC wrap, hazard split, async reset.
module tb_fetch_issue;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [63:0] imem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        issue_valid;
    logic        issue_ready;
    logic [63:0] issue_bundle;
    logic [1:0]  issue_lane_valid;
    logic [11:0] issue_pc;

    logic        s_req;
    logic [3:0]  s_addr;
    logic [31:0] s_rdata;
    logic        s_redir;
    logic [3:0]  s_redir_pc;
    logic        s_valid;
    logic [31:0] s_bundle;
    logic [0:0]  s_lanes;
    logic [3:0]  s_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_issue #(.LANES(2), .PC_W(12), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_bundle(issue_bundle), .issue_lane_valid(issue_lane_valid),
        .issue_pc(issue_pc)
    );

    fetch_issue #(.LANES(1), .PC_W(4), .QDEPTH(4)) u_small (
        .clk(clk), .rst(rst),
        .imem_req(s_req), .imem_addr(s_addr), .imem_rdata(s_rdata),
        .redirect_valid(s_redir), .redirect_pc(s_redir_pc),
        .issue_valid(s_valid), .issue_ready(1'b1),
        .issue_bundle(s_bundle), .issue_lane_valid(s_lanes),
        .issue_pc(s_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem2(input logic [11:0] a);
        logic [63:0] r;
        case (a)
            12'h100: r = {32'h00100293, 32'h00528333};
            12'h101: r = {32'h00100013, 32'h00000333};
            default: r = {4'hA, 4'h0, a, 12'h000, 4'hA, 4'h1, a, 12'h000};
        endcase
        return r;
    endfunction

    // One-cycle memory latency models.
    always @(posedge clk) if (imem_req) imem_rdata <= mem2(imem_addr);
    always @(posedge clk) if (s_req) s_rdata <= {8'h5A, 20'h0, s_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; issue_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        s_redir = 1'b0; s_redir_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 64'(imem_req), 0);
        check("rst_addr", 64'(imem_addr), 0);
        check("rst_valid", 64'(issue_valid), 0);
        check("rst_lanes", 64'(issue_lane_valid), 0);

        // Reset release with the consumer always ready.
        issue_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("c0_req", 64'(imem_req), 1);
        check("c0_addr", 64'(imem_addr), 0);
        step();
        check("c1_valid", 64'(issue_valid), 0);
        check("c1_addr", 64'(imem_addr), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", 64'(issue_valid), 1);
            check("stream_pc", 64'(issue_pc), 64'(i));
            check("stream_addr", 64'(imem_addr), 64'(i + 2));
            check("stream_bundle", issue_bundle, mem2(12'(i)));
            check("stream_lanes", 64'(issue_lane_valid), 64'h3);
        end

        // Stall: head pc 5 held, queue fills to four, fetch stops.
        issue_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", 64'(issue_valid), 1);
            check("stall_pc", 64'(issue_pc), 5);
            check("stall_bundle", issue_bundle, mem2(12'h5));
            check("stall_lanes", 64'(issue_lane_valid), 64'h3);
            check("stall_req", 64'(imem_req), (i == 0) ? 64'd1 : 64'd0);
        end
        issue_ready = 1'b1;
        #1;
        check("rel_pc", 64'(issue_pc), 5);
        check("rel_req", 64'(imem_req), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("rel_drain_pc", 64'(issue_pc), 64'(5 + i));
            check("rel_drain_valid", 64'(issue_valid), 1);
            check("rel_drain_req", 64'(imem_req), 1);
            check("rel_drain_addr", 64'(imem_addr), 64'(8 + i));
        end

        // Build 3 queued bundles (10,11,12) plus 13 in flight, then redirect.
        issue_ready = 1'b0;
        step();
        check("pre_redir_pc", 64'(issue_pc), 64'd10);
        check("pre_redir_req", 64'(imem_req), 0);
        redirect_valid = 1'b1; redirect_pc = 12'h02A; issue_ready = 1'b1;
        #1;
        check("redir_req", 64'(imem_req), 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("redir_flush_valid", 64'(issue_valid), 0);
        check("redir_flush_lanes", 64'(issue_lane_valid), 0);
        check("redir_req1", 64'(imem_req), 1);
        check("redir_addr1", 64'(imem_addr), 64'h2A);
        step();
        check("redir_valid2", 64'(issue_valid), 0);
        check("redir_addr2", 64'(imem_addr), 64'h2B);
        step();
        check("redir_issue_valid", 64'(issue_valid), 1);
        check("redir_issue_pc", 64'(issue_pc), 64'h2A);
        check("redir_issue_bundle", issue_bundle, mem2(12'h02A));
        step();
        check("redir_issue_pc2", 64'(issue_pc), 64'h2B);

        // Back-to-back redirects: the last target wins.
        redirect_valid = 1'b1; redirect_pc = 12'h050;
        step();
        redirect_pc = 12'h070;
        #1;
        check("b2b_valid", 64'(issue_valid), 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("b2b_addr", 64'(imem_addr), 64'h70);
        check("b2b_req", 64'(imem_req), 1);
        step();
        check("b2b_valid2", 64'(issue_valid), 0);
        step();
        check("b2b_pc", 64'(issue_pc), 64'h70);
        check("b2b_issue_valid", 64'(issue_valid), 1);

        // Hazard bundle at 0x100, x0-destination bundle at 0x101.
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        step();
        redirect_valid = 1'b0;
        #1;
        check("hz_addr", 64'(imem_addr), 64'h100);
        step();
        step();
        check("hz_pc0", 64'(issue_pc), 64'h100);
        check("hz_bundle0", issue_bundle, mem2(12'h100));
`ifdef FETCH_HAZARD_SPLIT_EN
        check("hz_mask0", 64'(issue_lane_valid), 64'h1);
        step();
        check("hz_pc1", 64'(issue_pc), 64'h100);
        check("hz_bundle1", issue_bundle, mem2(12'h100));
        check("hz_mask1", 64'(issue_lane_valid), 64'h2);
        step();
        check("hz_x0_pc", 64'(issue_pc), 64'h101);
        check("hz_x0_mask", 64'(issue_lane_valid), 64'h3);
        step();
        check("hz_next_pc", 64'(issue_pc), 64'h102);
`else
        check("hz_mask0", 64'(issue_lane_valid), 64'h3);
        step();
        check("hz_x0_pc", 64'(issue_pc), 64'h101);
        check("hz_x0_mask", 64'(issue_lane_valid), 64'h3);
        step();
        check("hz_next_pc", 64'(issue_pc), 64'h102);
`endif

        // Narrow PC wraps modulo 16.
        s_redir = 1'b1; s_redir_pc = 4'hE;
        #1;
        check("wrap_redir_req", 64'(s_req), 0);
        step();
        s_redir = 1'b0;
        #1;
        check("wrap_addr0", 64'(s_addr), 64'hE);
        step();
        check("wrap_addr1", 64'(s_addr), 64'hF);
        step();
        check("wrap_addr2", 64'(s_addr), 64'h0);
        check("wrap_issue_pc", 64'(s_pc), 64'hE);
        check("wrap_issue_data", 64'(s_bundle), 64'h5A00000E);
        step();
        check("wrap_addr3", 64'(s_addr), 64'h1);
        check("wrap_req3", 64'(s_req), 1);

        // Asynchronous reset mid-cycle during a stall.
        issue_ready = 1'b0;
        repeat (6) step();
        check("ar_pre_valid", 64'(issue_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(issue_valid), 0);
        check("ar_lanes", 64'(issue_lane_valid), 0);
        check("ar_req", 64'(imem_req), 0);
        check("ar_addr", 64'(imem_addr), 0);
        step();
        step();
        #2;
        issue_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("ar_rel_req", 64'(imem_req), 1);
        check("ar_rel_addr", 64'(imem_addr), 0);
        step();
        check("ar_c1_valid", 64'(issue_valid), 0);
        check("ar_c1_addr", 64'(imem_addr), 1);
        step();
        check("ar_c2_valid", 64'(issue_valid), 1);
        check("ar_c2_pc", 64'(issue_pc), 0);
        check("ar_c2_bundle", issue_bundle, mem2(12'h000));
        step();
        check("ar_c3_pc", 64'(issue_pc), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
